alu_seq: RTL

//  Handshaked, multi-cycle ALU: responder side of the op_sel/a/b -> out interface our ALU benches drive.

---
 rtl/alu_seq_if.sv | 22 ++
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Command/result handshake bundle for alu_seq: op_sel/a/b in, result/err out.
interface alu_seq_if #(parameter int WIDTH = 4);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [3:0]           op_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 err;

    modport master (
        output in_valid, a, b, op_sel, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, a, b, op_sel, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith, shift-add multiply, restoring divide.
// Divider is built only when ALU_DIV_EN is defined; otherwise ops 3/4 report err like invalid opcodes.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state;
    logic                 in_ready_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 err_q;
    logic [CW-1:0]        cnt;

    logic [2*WIDTH-1:0]   mul_acc;
    logic [2*WIDTH-1:0]   mul_cand;
    logic [WIDTH-1:0]     mul_plier;
    logic [2*WIDTH-1:0]   acc_nx;

    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;
    logic [2*WIDTH-1:0]   quick_res;
    logic                 quick_err;
    logic                 accept;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
    assign bus.err       = err_q;

    assign accept = bus.in_valid && in_ready_q;
    assign a_ext  = {{WIDTH{1'b0}}, bus.a};
    assign b_ext  = {{WIDTH{1'b0}}, bus.b};

    always_comb begin
        acc_nx = mul_plier[0] ? (mul_acc + mul_cand) : mul_acc;
    end

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_sor;
    logic             div_mod;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             start_div;

    assign start_div = ((bus.op_sel == 4'd3) || (bus.op_sel == 4'd4)) && (bus.b != '0);

    // Restoring step: dividend bits shift out of the quotient register into the remainder.
    always_comb begin
        rem_sh = {div_rem, div_quo[WIDTH-1]};
        quo_nx = {div_quo[WIDTH-2:0], 1'b0};
        rem_nx = rem_sh[WIDTH-1:0];
        if (rem_sh >= {1'b0, div_sor}) begin
            rem_nx = WIDTH'(rem_sh - {1'b0, div_sor});
            quo_nx = {div_quo[WIDTH-2:0], 1'b1};
        end
    end
`endif

    always_comb begin
        quick_res = '0;
        quick_err = 1'b0;
        case (bus.op_sel)
            4'd0:  quick_res = a_ext + b_ext;
            4'd1:  quick_res = a_ext - b_ext;
            4'd2:  quick_res = '0;
`ifdef ALU_DIV_EN
            4'd3: begin
                if (bus.b == '0) begin
                    quick_res = '1;
                    quick_err = 1'b1;
                end
            end
            4'd4: begin
                if (bus.b == '0) begin
                    quick_res = a_ext;
                    quick_err = 1'b1;
                end
            end
`endif
            4'd5:  quick_res = {{WIDTH{1'b0}}, bus.a & bus.b};
            4'd6:  quick_res = {{WIDTH{1'b0}}, bus.a | bus.b};
            4'd7:  quick_res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
            4'd8:  quick_res = {{WIDTH{1'b0}}, ~(bus.a ^ bus.b)};
            4'd9:  quick_res = {{WIDTH{1'b0}}, ~bus.a};
            4'd10: quick_res = {{WIDTH{1'b0}}, ~bus.b};
            4'd11: quick_res = a_ext << bus.b;
            4'd12: quick_res = a_ext >> bus.b;
            default: quick_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_ready_q <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            mul_acc    <= '0;
            mul_cand   <= '0;
            mul_plier  <= '0;
`ifdef ALU_DIV_EN
            div_rem    <= '0;
            div_quo    <= '0;
            div_sor    <= '0;
            div_mod    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        cnt        <= CW'(WIDTH - 1);
                        if (bus.op_sel == 4'd2) begin
                            mul_acc   <= '0;
                            mul_cand  <= a_ext;
                            mul_plier <= bus.b;
                            state     <= S_MUL;
                        end
`ifdef ALU_DIV_EN
                        else if (start_div) begin
                            div_rem <= '0;
                            div_quo <= bus.a;
                            div_sor <= bus.b;
                            div_mod <= (bus.op_sel == 4'd4);
                            state   <= S_DIV;
                        end
`endif
                        else begin
                            result_q <= quick_res;
                            err_q    <= quick_err;
                            state    <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    mul_acc   <= acc_nx;
                    mul_cand  <= mul_cand << 1;
                    mul_plier <= mul_plier >> 1;
                    cnt       <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_q <= acc_nx;
                        err_q    <= 1'b0;
                        state    <= S_DONE;
                    end
                end
`ifdef ALU_DIV_EN
                S_DIV: begin
                    div_rem <= rem_nx;
                    div_quo <= quo_nx;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_q <= div_mod ? {{WIDTH{1'b0}}, rem_nx} : {{WIDTH{1'b0}}, quo_nx};
                        err_q    <= 1'b0;
                        state    <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        state      <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
